// File: rtl/rotator_reg_if.sv
// rotator_reg_if: control/data bundle for rotator_reg.
//   master : drives data_in, load, start, steps, dir, asr; observes q, busy, done
//   slave  : the register stage itself
// With ROTATOR_REG_SERIAL_OUT_EN defined the bundle also carries serial_out.
interface rotator_reg_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
);
  logic [WIDTH-1:0]  data_in;
  logic              load;
  logic              start;
  logic [STEP_W-1:0] steps;
  logic              dir;
  logic              asr;
  logic [WIDTH-1:0]  q;
  logic              busy;
  logic              done;
`ifdef ROTATOR_REG_SERIAL_OUT_EN
  logic              serial_out;

  modport master (output data_in, load, start, steps, dir, asr,
                  input  q, busy, done, serial_out);
  modport slave  (input  data_in, load, start, steps, dir, asr,
                  output q, busy, done, serial_out);
`else
  modport master (output data_in, load, start, steps, dir, asr,
                  input  q, busy, done);
  modport slave  (input  data_in, load, start, steps, dir, asr,
                  output q, busy, done);
`endif
endinterface

// File: rtl/rotator_reg.sv
// rotator_reg: WIDTH-bit register with parallel load and a programmed
// rotate-left / rotate-right / arithmetic-shift-right sequence, one step
// per clock, under a start/busy/done handshake.
//   clock   : rising-edge clock
//   reset_b : asynchronous active-low reset
//   bus     : rotator_reg_if.slave (data_in, load, start, steps, dir, asr
//             in; q, busy, done out)
// Optional: define ROTATOR_REG_SERIAL_OUT_EN to add bus.serial_out, the
// bit shifted out by the most recent step (cleared by a parallel load).
module rotator_reg #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic         clock,
  input  logic         reset_b,
  rotator_reg_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              asr_q, asr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  stepped;
`ifdef ROTATOR_REG_SERIAL_OUT_EN
  logic              ser_q, ser_d;
  logic              leaving;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      asr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ROTATOR_REG_SERIAL_OUT_EN
      ser_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      asr_q   <= asr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ROTATOR_REG_SERIAL_OUT_EN
      ser_q   <= ser_d;
`endif
    end
  end

  // One step of the captured operation
  always_comb begin
    if (!dir_q) begin
      stepped = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
    end else begin
      stepped = {(asr_q ? q_q[WIDTH-1] : q_q[0]), q_q[WIDTH-1:1]};
    end
`ifdef ROTATOR_REG_SERIAL_OUT_EN
    leaving = dir_q ? q_q[0] : q_q[WIDTH-1];
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.load && bus.start) begin
          state_d = (bus.steps != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (cnt_q == STEP_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and handshake outputs; busy/done are registered from state_d
  // so they line up exactly with state_q.
  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    asr_d = asr_q;
`ifdef ROTATOR_REG_SERIAL_OUT_EN
    ser_d = ser_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          q_d = bus.data_in;
`ifdef ROTATOR_REG_SERIAL_OUT_EN
          ser_d = 1'b0;
`endif
        end else if (bus.start) begin
          cnt_d = bus.steps;
          dir_d = bus.dir;
          asr_d = bus.asr;
        end
      end
      S_RUN: begin
        q_d   = stepped;
        cnt_d = cnt_q - STEP_W'(1);
`ifdef ROTATOR_REG_SERIAL_OUT_EN
        ser_d = leaving;
`endif
      end
      default: ;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  assign bus.q    = q_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef ROTATOR_REG_SERIAL_OUT_EN
  assign bus.serial_out = ser_q;
`endif

endmodule

// File: tb/tb_rotator_reg.sv
// tb_rotator_reg: scoreboard bench for rotator_reg (WIDTH=8, STEP_W=4).
// Expected final words are queued when a sequence is started and popped
// when the done pulse is seen.
module tb_rotator_reg;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] sb[$];

  rotator_reg_if #(.WIDTH(8), .STEP_W(4)) bus_if ();

  rotator_reg #(.WIDTH(8), .STEP_W(4)) dut (
    .clock  (clk),
    .reset_b(rst_n),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] v, input int n,
                                       input bit d, input bit a);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) begin
      if (!d)     r = {r[6:0], r[7]};
      else if (a) r = {r[7], r[7:1]};
      else        r = {r[0], r[7:1]};
    end
    return r;
  endfunction

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    bus_if.load = 1'b1; bus_if.data_in = v;
    @(posedge clk); #1;
    bus_if.load = 1'b0;
  endtask

  task automatic do_start(input int n, input bit d, input bit a);
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.steps = 4'(n); bus_if.dir = d; bus_if.asr = a;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
  endtask

  // Watches for done (bounded); reports busy cycles before it, q in the
  // done cycle and done one cycle later.
  task automatic observe(output int bc, output bit seen,
                         output logic [7:0] qd, output logic dafter);
    bc = 0; seen = 1'b0; qd = 'x; dafter = 'x;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) begin seen = 1'b1; qd = bus_if.q; end
      else if (bus_if.busy === 1'b1) bc++;
    end
    if (seen) begin @(negedge clk); dafter = bus_if.done; end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_tests++; if (bus_if.q !== 8'h00) begin n_fail++; $display("FAIL reset_q got %h want 00", bus_if.q); end
    n_tests++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_flags busy=%b done=%b want 0/0", bus_if.busy, bus_if.done); end
    rst_n = 1'b1;
    do_load(8'h3C);
    @(posedge clk); #3 rst_n = 1'b0; #1;
    n_tests++; if (bus_if.q !== 8'h00) begin n_fail++; $display("FAIL async_reset_q got %h want 00", bus_if.q); end
    n_tests++; if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin n_fail++; $display("FAIL async_reset_flags busy=%b done=%b want 0/0", bus_if.busy, bus_if.done); end
`ifdef ROTATOR_REG_SERIAL_OUT_EN
    n_tests++; if (bus_if.serial_out !== 1'b0) begin n_fail++; $display("FAIL reset_serial got %b want 0", bus_if.serial_out); end
`endif
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load;
    do_load(8'hA5);
    @(negedge clk);
    n_tests++; if (bus_if.q !== 8'hA5) begin n_fail++; $display("FAIL load_q got %h want a5", bus_if.q); end
  endtask

  // Table: {start word, steps, dir, asr, expected}
  task automatic test_sequences;
    logic [7:0] init_v[7] = '{8'h81, 8'h90, 8'h90, 8'h66, 8'h3C, 8'h80, 8'h01};
    int         nst[7]    = '{3, 2, 2, 0, 8, 15, 15};
    bit         dv[7]     = '{0, 1, 1, 0, 0, 1, 1};
    bit         av[7]     = '{0, 1, 0, 0, 0, 1, 0};
    logic [7:0] exp_v[7]  = '{8'h0C, 8'hE4, 8'h24, 8'h66, 8'h3C, 8'hFF, 8'h02};
    int bc; bit seen; logic [7:0] qd, e; logic da;
    for (int i = 0; i < 7; i++) begin
      do_load(init_v[i]);
      do_start(nst[i], dv[i], av[i]);
      sb.push_back(exp_v[i]);
      observe(bc, seen, qd, da);
      e = sb.pop_front();
      n_tests++; if (!seen) begin n_fail++; $display("FAIL seq%0d_done never seen within 40 cycles", i); end
      n_tests++; if (qd !== e) begin n_fail++; $display("FAIL seq%0d_q got %h want %h", i, qd, e); end
      n_tests++; if (bc !== nst[i]) begin n_fail++; $display("FAIL seq%0d_busy_cycles got %0d want %0d", i, bc, nst[i]); end
      n_tests++; if (da !== 1'b0) begin n_fail++; $display("FAIL seq%0d_done_width done still %b a cycle later, want 0", i, da); end
    end
  endtask

  task automatic test_random;
    int bc; bit seen; logic [7:0] qd, e, v; logic da; int n; bit d, a;
    for (int i = 0; i < 5; i++) begin
      v = 8'($urandom); n = $urandom_range(0, 15); d = 1'($urandom); a = 1'($urandom);
      do_load(v);
      do_start(n, d, a);
      sb.push_back(model(v, n, d, a));
      observe(bc, seen, qd, da);
      e = sb.pop_front();
      n_tests++; if (!seen || qd !== e) begin n_fail++; $display("FAIL rand%0d_q v=%h n=%0d d=%b a=%b got %h want %h", i, v, n, d, a, qd, e); end
      n_tests++; if (bc !== n) begin n_fail++; $display("FAIL rand%0d_busy_cycles got %0d want %0d", i, bc, n); end
    end
  endtask

  task automatic test_priority;
    int bsy = 0, dn = 0;
    @(negedge clk);
    bus_if.load = 1'b1; bus_if.start = 1'b1; bus_if.steps = 4'd3; bus_if.dir = 1'b0; bus_if.data_in = 8'h5A;
    @(posedge clk); #1;
    bus_if.load = 1'b0; bus_if.start = 1'b0;
    n_tests++; if (bus_if.q !== 8'h5A) begin n_fail++; $display("FAIL prio_q got %h want 5a", bus_if.q); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_if.busy === 1'b1) bsy++;
      if (bus_if.done === 1'b1) dn++;
    end
    n_tests++; if (bsy !== 0 || dn !== 0) begin n_fail++; $display("FAIL prio_idle busy_cycles=%0d done_cycles=%0d want 0/0", bsy, dn); end
  endtask

  task automatic test_load_during_run;
    int bc, pre = 0; bit seen; logic [7:0] qd, e; logic da;
    do_load(8'h81);
    do_start(3, 0, 0);
    sb.push_back(8'h0C);
    @(negedge clk); if (bus_if.busy === 1'b1) pre++;
    bus_if.load = 1'b1; bus_if.data_in = 8'h00; bus_if.start = 1'b1; bus_if.dir = 1'b1; bus_if.asr = 1'b1; bus_if.steps = 4'd9;
    @(negedge clk); if (bus_if.busy === 1'b1) pre++;
    bus_if.load = 1'b0; bus_if.start = 1'b0; bus_if.dir = 1'b0; bus_if.asr = 1'b0;
    observe(bc, seen, qd, da);
    e = sb.pop_front();
    n_tests++; if (!seen || qd !== e) begin n_fail++; $display("FAIL run_ignore_q got %h want %h", qd, e); end
    n_tests++; if (pre + bc !== 3) begin n_fail++; $display("FAIL run_ignore_busy_cycles got %0d want 3", pre + bc); end
  endtask

  task automatic test_abort;
    int bsy = 0, dn = 0;
    do_load(8'h81);
    do_start(5, 0, 0);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    n_tests++; if (bus_if.q !== 8'h00 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      n_fail++; $display("FAIL abort_now q=%h busy=%b done=%b want 00/0/0", bus_if.q, bus_if.busy, bus_if.done);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_if.busy === 1'b1) bsy++;
      if (bus_if.done === 1'b1) dn++;
    end
    n_tests++; if (bsy !== 0 || dn !== 0) begin n_fail++; $display("FAIL abort_after busy_cycles=%0d done_cycles=%0d want 0/0", bsy, dn); end
    n_tests++; if (bus_if.q !== 8'h00) begin n_fail++; $display("FAIL abort_q got %h want 00", bus_if.q); end
  endtask

`ifdef ROTATOR_REG_SERIAL_OUT_EN
  task automatic test_serial_out;
    int bc; bit seen; logic [7:0] qd, e; logic da;
    do_load(8'h81);
    do_start(1, 0, 0);
    sb.push_back(8'h03);
    observe(bc, seen, qd, da);
    e = sb.pop_front();
    n_tests++; if (!seen || qd !== e) begin n_fail++; $display("FAIL serial_q got %h want %h", qd, e); end
    n_tests++; if (bus_if.serial_out !== 1'b1) begin n_fail++; $display("FAIL serial_bit got %b want 1", bus_if.serial_out); end
    do_load(8'h00);
    @(negedge clk);
    n_tests++; if (bus_if.serial_out !== 1'b0) begin n_fail++; $display("FAIL serial_clear got %b want 0", bus_if.serial_out); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus_if.data_in = '0; bus_if.load = 1'b0; bus_if.start = 1'b0;
    bus_if.steps = '0; bus_if.dir = 1'b0; bus_if.asr = 1'b0;
    test_reset;
    test_load;
    test_sequences;
    test_random;
    test_priority;
    test_load_during_run;
    test_abort;
`ifdef ROTATOR_REG_SERIAL_OUT_EN
    test_serial_out;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rotator_reg.md
Name: rotator_reg

Overview:
- Sequential register stage sitting directly downstream of the team's 2-to-1 multiplexer.
- Each bit's next-state is chosen by a per-bit 2-to-1 select: parallel-load versus shift/rotate.
- Holds a WIDTH-bit word and applies a programmed number of rotate/shift steps, one step per clock, under a start/busy/done handshake.
- Drives the board LEDs/HEX stage and is driven by switches/keys in the lab top level.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- STEP_W, 4, width of the step-count input; must hold values 0..WIDTH.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  parallel load value.
- load  input  1  parallel-load request, level-sampled.
- start  input  1  begin a step sequence, level-sampled.
- steps  input  STEP_W  number of steps to perform, captured at start.
- dir  input  1  0 = left (toward MSB), 1 = right.
- asr  input  1  with dir=1: arithmetic shift right (MSB replicated) instead of rotate; ignored when dir=0.
- q  output  WIDTH  register contents.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a sequence completes.

Behaviour:
- Reset (reset_b=0, asynchronous, any state): q=0, busy=0, done=0, state=IDLE, step counter=0, captured dir/asr=0. On release, the first active edge is treated as IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - load=1 → q<=data_in; stay IDLE.
  - load=1 with start=1 → load wins; start ignored.
  - start=1, load=0, steps≠0 → capture steps/dir/asr; go to RUN.
  - start=1, load=0, steps=0 → go to DONE; q unchanged.
- RUN:
  - Each cycle apply one step using the captured dir/asr; decrement the counter.
  - Counter reaching 0 after a step → go to DONE.
  - load, start, dir, asr and steps are ignored while in RUN.
- DONE: done=1 for exactly this cycle; go to IDLE next edge. start held high does not retrigger until the cycle after DONE (IDLE samples it again).
- Step operations, with q=b[W-1..0]:
  - Rotate left: {b[W-2..0], b[W-1]}.
  - Rotate right: {b[0], b[W-1..1]}.
  - ASR: {b[W-1], b[W-1..1]}.
- Latency: start sampled at edge k with N≥1 steps → busy high for cycles k+1..k+N; q reflects all N steps after edge k+N; done high in cycle k+N+1. With N=0, done is high in cycle k+1.
- steps > WIDTH is legal: rotation wraps (WIDTH steps returns the original word); ASR saturates to all-sign bits.
- busy=1 exactly when state=RUN; done=1 exactly when state=DONE; both are registered.
- Reset asserted mid-RUN aborts immediately: all outputs go to reset values, and no done pulse is produced.

Optional Feature:
- Macro ROTATOR_REG_SERIAL_OUT_EN.
- Defined:
  - Adds output port serial_out (1 bit, reset 0).
  - Each RUN step registers the bit leaving the word: b[W-1] for left, b[0] for right/ASR.
  - Holds that value otherwise.
  - A parallel load clears it to 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then load: reset_b=0 mid-cycle → q=0x00, busy=0, done=0 immediately; release, load=1, data_in=0xA5 → q=0xA5 next edge.
- Rotate left: q=0x81, start with steps=3, dir=0 → busy for 3 cycles, q=0x0C, then done pulse of exactly 1 cycle.
- ASR vs rotate right: q=0x90, steps=2, dir=1, asr=1 → q=0xE4. Repeat from 0x90 with asr=0 → q=0x24.
- Edge counts:
  - steps=0 → done next cycle, q unchanged.
  - steps=8 rotate on 0x3C → q=0x3C.
  - steps=15 ASR on 0x80 → q=0xFF.
- Priority/ignore:
  - load=1 and start=1 together in IDLE → load taken, busy stays 0.
  - load=1, data_in=0x00 during RUN → ignored; final q matches the no-load run.
- Abort: reset_b=0 at 2nd RUN cycle of a 5-step run → q=0, busy=0, no done. With ROTATOR_REG_SERIAL_OUT_EN: rotate-left of 0x81 by 1 → serial_out=1.
